// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide sequencer sharing the execute-stage ALU.
// Multiply is shift-add (one ALU ADD per cycle); divide is restoring (one ALU SUB per cycle).
// Optional feature macro: MULDIV_SIGNED_EN (signed MULH/MULHSU/DIV/REM via magnitude + FIX state).
// Ports:
//   clk_i, rst_ni                     clock, async active-low reset
//   req_valid_i/req_ready_o           request handshake; op_i (funct3), a_i (rs1), b_i (rs2)
//   kill_i                            flush: abandon the current operation
//   rsp_valid_o/rsp_ready_i, result_o response handshake and result
//   alu_own_o                         sequencer owns the ALU (ALU input mux select)
//   alu_ctl_o, alu_a_o, alu_b_o       ALU control and operands
//   alu_result_i                      combinational ALU result, same cycle
module muldiv_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ITER_W     = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  kill_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  alu_own_o,
  output logic [3:0]            alu_ctl_o,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i
);

  localparam int unsigned DW = DATA_WIDTH;
  // ALU control encodings shared with the ALU's alu.vh
  localparam logic [3:0]        ALU_ADD = 4'h0;
  localparam logic [3:0]        ALU_SUB = 4'h1;
  localparam logic [ITER_W-1:0] LAST_IT = ITER_W'(DW - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state;
  logic [ITER_W-1:0] cnt;
  logic [2:0]        op_q;
  logic [DW-1:0]     acc_hi;   // hi (multiply) / rem (divide)
  logic [DW-1:0]     acc_lo;   // lo (multiply) / q (divide)

  logic [DW-1:0]     sh;
  logic [DW-1:0]     s;
  logic              c;
  logic [DW-1:0]     hi_n;
  logic [DW-1:0]     lo_n;
  logic [DW-1:0]     a_next;
  logic [DW-1:0]     a_mag;
  logic [DW-1:0]     b_mag;

  // Result word selection: MUL, DIV, DIVU take the low/quotient half, the rest take hi/rem
  function automatic logic [DW-1:0] res_sel(input logic [2:0] op,
                                             input logic [DW-1:0] hi,
                                             input logic [DW-1:0] lo);
    return ((op == 3'b000) || (op[2:1] == 2'b10)) ? lo : hi;
  endfunction

  // One iteration step, using the ALU result of the current cycle
  always_comb begin
    sh     = {acc_hi[DW-2:0], acc_lo[DW-1]};
    s      = acc_hi;
    c      = 1'b0;
    hi_n   = acc_hi;
    lo_n   = acc_lo;
    a_next = '0;
    if (op_q[2]) begin
      // rem[31] set means the true 33-bit shifted remainder already exceeds the divisor
      if (acc_hi[DW-1] || (sh >= alu_b_o)) begin
        hi_n = alu_result_i;
        lo_n = {acc_lo[DW-2:0], 1'b1};
      end else begin
        hi_n = sh;
        lo_n = {acc_lo[DW-2:0], 1'b0};
      end
      a_next = {hi_n[DW-2:0], lo_n[DW-1]};
    end else begin
      if (acc_lo[0]) begin
        s = alu_result_i;
        c = (alu_result_i < acc_hi);
      end
      {hi_n, lo_n} = {c, s, acc_lo[DW-1:1]};
      a_next = hi_n;
    end
  end

`ifdef MULDIV_SIGNED_EN
  logic          sgn_a;
  logic          sgn_b;
  logic          a_neg;
  logic          b_neg;
  logic          neg_c;
  logic          fix_en;
  logic          fix_neg;
  logic [DW-1:0] fix_result;
  logic [2*DW-1:0] prod_neg;

  // Convert signed operands to magnitudes at accept and record the result sign
  always_comb begin
    sgn_a = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
    sgn_b = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
    a_neg = sgn_a & a_i[DW-1];
    b_neg = sgn_b & b_i[DW-1];
    a_mag = a_neg ? (~a_i + DW'(1)) : a_i;
    b_mag = b_neg ? (~b_i + DW'(1)) : b_i;
    // remainder follows the dividend sign; product and quotient follow sign difference
    neg_c = (op_i[2] & op_i[1]) ? a_neg : (a_neg ^ b_neg);
  end

  // Sign correction applied in FIX; MULH* negate the whole 64-bit product
  always_comb begin
    prod_neg   = ~{acc_hi, acc_lo} + (2*DW)'(1);
    fix_result = res_sel(op_q, acc_hi, acc_lo);
    if (fix_neg) begin
      if (!op_q[2])     fix_result = prod_neg[2*DW-1:DW];
      else if (op_q[1]) fix_result = ~acc_hi + DW'(1);
      else              fix_result = ~acc_lo + DW'(1);
    end
  end
`else
  always_comb begin
    a_mag = a_i;
    b_mag = b_i;
  end
`endif

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_q        <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      result_o    <= '0;
      alu_own_o   <= 1'b0;
      alu_ctl_o   <= ALU_ADD;
      alu_a_o     <= '0;
      alu_b_o     <= '0;
`ifdef MULDIV_SIGNED_EN
      fix_en      <= 1'b0;
      fix_neg     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid_i && req_ready_o && !kill_i) begin
            op_q        <= op_i;
            cnt         <= '0;
            req_ready_o <= 1'b0;
            if (op_i[2] && (b_i == '0)) begin
              // divide by zero: quotient all ones, remainder is the raw dividend
              state       <= S_DONE;
              rsp_valid_o <= 1'b1;
              result_o    <= op_i[1] ? a_i : '1;
            end else begin
              state     <= S_CALC;
              acc_hi    <= '0;
              acc_lo    <= a_mag;
              alu_own_o <= 1'b1;
              alu_ctl_o <= op_i[2] ? ALU_SUB : ALU_ADD;
              alu_a_o   <= op_i[2] ? {{(DW-1){1'b0}}, a_mag[DW-1]} : '0;
              alu_b_o   <= b_mag;
`ifdef MULDIV_SIGNED_EN
              fix_en    <= sgn_a;
              fix_neg   <= neg_c;
`endif
            end
          end
        end

        S_CALC: begin
          if (kill_i) begin
            state       <= S_IDLE;
            req_ready_o <= 1'b1;
            alu_own_o   <= 1'b0;
            alu_ctl_o   <= ALU_ADD;
            alu_a_o     <= '0;
            alu_b_o     <= '0;
          end else begin
            acc_hi  <= hi_n;
            acc_lo  <= lo_n;
            alu_a_o <= a_next;
            cnt     <= cnt + ITER_W'(1);
            if (cnt == LAST_IT) begin
              alu_own_o <= 1'b0;
              alu_ctl_o <= ALU_ADD;
              alu_a_o   <= '0;
              alu_b_o   <= '0;
`ifdef MULDIV_SIGNED_EN
              if (fix_en) state <= S_FIX;
              else
`endif
              begin
                state       <= S_DONE;
                rsp_valid_o <= 1'b1;
                result_o    <= res_sel(op_q, hi_n, lo_n);
              end
            end
          end
        end

`ifdef MULDIV_SIGNED_EN
        S_FIX: begin
          if (kill_i) begin
            state       <= S_IDLE;
            req_ready_o <= 1'b1;
          end else begin
            state       <= S_DONE;
            rsp_valid_o <= 1'b1;
            result_o    <= fix_result;
          end
        end
`endif

        S_DONE: begin
          // kill and consume both return to IDLE; either way the result is gone
          if (kill_i || rsp_ready_i) begin
            state       <= S_IDLE;
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end

        default: begin
          state       <= S_IDLE;
          req_ready_o <= 1'b1;
          rsp_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and randomized checks of muldiv_seq against an arithmetic model.
module tb_muldiv_seq;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  op_i = '0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        kill_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] result_o;
  logic        alu_own_o;
  logic [3:0]  alu_ctl_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic [31:0] alu_result_i;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.DATA_WIDTH(32), .ITER_W(6)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .op_i         (op_i),
    .a_i          (a_i),
    .b_i          (b_i),
    .kill_i       (kill_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .result_o     (result_o),
    .alu_own_o    (alu_own_o),
    .alu_ctl_o    (alu_ctl_o),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_result_i (alu_result_i)
  );

  always #5 clk_i = ~clk_i;

  // Shared ALU stand-in
  always_comb begin
    alu_result_i = (alu_ctl_o == ALU_SUB) ? (alu_a_o - alu_b_o) : (alu_a_o + alu_b_o);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit signed_build();
`ifdef MULDIV_SIGNED_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: RV32M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    bit              sgn;
    sgn = signed_build();
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sgn ? 64'(sa * sb) : ua * ub; return p[63:32]; end
      3'd2: begin p = sgn ? 64'(sa * longint'(ub)) : ua * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4, 3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (op == 3'd4 && sgn) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
          return 32'(sa / sb);
        end
        return 32'(ua / ub);
      end
      default: begin
        if (b == 32'd0) return a;
        if (op == 3'd6 && sgn) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
          return 32'(sa % sb);
        end
        return 32'(ua % ub);
      end
    endcase
  endfunction

  // Issue one operation, check latency, ALU usage, result and the DONE handshake
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int stall);
    int          exp_lat;
    int          cyc;
    int          own;
    int          bad;
    int          hold_bad;
    bit          dz;
    bit          need_fix;
    logic [31:0] hold;
    dz       = op[2] && (b == 32'd0);
    need_fix = signed_build() && (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6);
    exp_lat  = dz ? 1 : (need_fix ? 34 : 33);
    @(negedge clk_i);
    check("ready_idle", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    op_i = op;
    a_i  = a;
    b_i  = b;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    cyc = 1;
    own = 0;
    bad = 0;
    while (!rsp_valid_o && cyc < 100) begin
      if (alu_own_o) begin
        own++;
        if (alu_ctl_o !== (op[2] ? ALU_SUB : ALU_ADD)) bad++;
      end else if (alu_ctl_o !== ALU_ADD || alu_a_o !== 32'd0 || alu_b_o !== 32'd0) begin
        bad++;
      end
      if (req_ready_o) bad++;
      @(posedge clk_i);
      #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(exp_lat));
    check("alu_own_cycles", 32'(own), dz ? 32'd0 : 32'd32);
    check("alu_ctl_seq", 32'(bad), 32'd0);
    check("result", result_o, exp);
    check("ready_in_done", 32'(req_ready_o), 32'd0);
    hold     = result_o;
    hold_bad = 0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk_i);
      #1;
      if (result_o !== hold || rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0 || alu_own_o !== 1'b0)
        hold_bad++;
    end
    if (stall > 0) check("done_stall_hold", 32'(hold_bad), 32'd0);
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid_o), 32'd0);
    check("ready_return", 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    int          seen;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    // reset values while held in reset
    #12;
    check("rst_ready", 32'(req_ready_o), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_alu_own", 32'(alu_own_o), 32'd0);
    check("rst_alu_ctl", 32'(alu_ctl_o), 32'(ALU_ADD));
    check("rst_alu_a", alu_a_o, 32'd0);
    check("rst_alu_b", alu_b_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // directed unsigned cases
    do_op(3'd0, 32'd7, 32'd6, 32'd42, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    do_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    do_op(3'd5, 32'd100, 32'd7, 32'd14, 0);
    do_op(3'd7, 32'd100, 32'd7, 32'd2, 0);
    do_op(3'd5, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0);
    do_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    do_op(3'd7, 32'd5, 32'd0, 32'd5, 0);
    do_op(3'd0, 32'd3, 32'd5, 32'd15, 5);
    do_op(3'd7, 32'd9, 32'd0, 32'd9, 5);

`ifdef MULDIV_SIGNED_EN
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 0);
`endif

    // kill at CALC iteration 10
    @(negedge clk_i);
    req_valid_i = 1'b1;
    op_i = 3'd0;
    a_i  = 32'd123;
    b_i  = 32'd456;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    kill_i = 1'b1;
    @(posedge clk_i);
    #1;
    kill_i = 1'b0;
    check("kill_ready", 32'(req_ready_o), 32'd1);
    check("kill_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("kill_alu_own", 32'(alu_own_o), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk_i);
      #1;
      if (rsp_valid_o || alu_own_o) seen++;
    end
    check("kill_no_rsp", 32'(seen), 32'd0);
    do_op(3'd0, 32'd123, 32'd456, 32'd56088, 0);

    // kill in IDLE blocks a same-cycle request
    @(negedge clk_i);
    req_valid_i = 1'b1;
    kill_i = 1'b1;
    op_i = 3'd5;
    a_i  = 32'd10;
    b_i  = 32'd0;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    kill_i = 1'b0;
    check("idle_kill_ready", 32'(req_ready_o), 32'd1);
    check("idle_kill_rsp", 32'(rsp_valid_o), 32'd0);
    check("idle_kill_own", 32'(alu_own_o), 32'd0);

    // randomized operations
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'($urandom_range(0, 50));
        2:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      do_op(rop, ra, rb, ref_model(rop, ra, rb), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
